// File: rtl/dual_req_logic_arbiter_if.sv
// Request/grant/result bundle between two requesters and the shared logic unit.
// The master modport is the requester side; the slave modport is the arbiter.
interface dual_req_logic_arbiter_if;
    logic       req0;
    logic       req1;
    logic [1:0] op0;
    logic [1:0] op1;
    logic [7:0] a0;
    logic [7:0] b0;
    logic [7:0] a1;
    logic [7:0] b1;
    logic       gnt0;
    logic       gnt1;
    logic       busy;
    logic [7:0] result;
    logic       done;
    logic       done_id;

    modport master (
        output req0, req1, op0, op1, a0, b0, a1, b1,
        input  gnt0, gnt1, busy, result, done, done_id
    );

    modport slave (
        input  req0, req1, op0, op1, a0, b0, a1, b1,
        output gnt0, gnt1, busy, result, done, done_id
    );
endinterface

// File: rtl/dual_req_logic_arbiter.sv
// Round-robin arbiter in front of one shared 8-bit bitwise logic unit.
// Each operation takes IDLE/DONE -> LOAD -> EXEC -> DONE.
module dual_req_logic_arbiter (
    input  logic                      clk,
    input  logic                      rst_n,
    dual_req_logic_arbiter_if.slave   bus
);

    typedef enum logic [1:0] {IDLE, LOAD, EXEC, DONE} state_t;

    state_t     state;
    logic       last_id;
    logic       cur_id;
    logic [1:0] op_q;
    logic [7:0] a_q;
    logic [7:0] b_q;
    logic       win_id;

    // A lone request always wins; a tie goes to whoever did not win last.
    assign win_id = (bus.req0 && bus.req1) ? ~last_id : bus.req1;

    function automatic logic [7:0] logic_op(input logic [1:0] op,
                                            input logic [7:0] a,
                                            input logic [7:0] b);
        case (op)
            2'b00:   return a & b;
            2'b01:   return a | b;
            2'b10:   return a ^ b;
            default: return ~(a ^ b);
        endcase
    endfunction

    // NOTE: state is updated with non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state       <= IDLE;
            last_id     <= 1'b1;
            cur_id      <= 1'b0;
            bus.gnt0    <= 1'b0;
            bus.gnt1    <= 1'b0;
            bus.busy    <= 1'b0;
            bus.done    <= 1'b0;
            bus.done_id <= 1'b0;
            bus.result  <= 8'h00;
            // NOTE: captured operands are not reset; they are only read after a
            // capture in IDLE/DONE has loaded them.
        end else begin
            bus.gnt0 <= 1'b0;
            bus.gnt1 <= 1'b0;
            bus.done <= 1'b0;
            case (state)
                IDLE, DONE: begin
                    if (bus.req0 || bus.req1) begin
                        state    <= LOAD;
                        bus.busy <= 1'b1;
                        op_q     <= win_id ? bus.op1 : bus.op0;
                        a_q      <= win_id ? bus.a1  : bus.a0;
                        b_q      <= win_id ? bus.b1  : bus.b0;
                        bus.gnt0 <= ~win_id;
                        bus.gnt1 <= win_id;
                        last_id  <= win_id;
                        cur_id   <= win_id;
                    end else begin
                        state    <= IDLE;
                        bus.busy <= 1'b0;
                    end
                end
                LOAD: begin
                    state <= EXEC;
                end
                EXEC: begin
                    state       <= DONE;
                    bus.result  <= logic_op(op_q, a_q, b_q);
                    bus.done    <= 1'b1;
                    bus.done_id <= cur_id;
                end
                default: begin
                    state    <= IDLE;
                    bus.busy <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_dual_req_logic_arbiter.sv
// Directed scoreboard bench: stimulus pushes expected grants and results,
// a monitor pops and compares whenever a grant or done is presented.
module tb_dual_req_logic_arbiter;

    logic clk;
    logic rst_n;

    dual_req_logic_arbiter_if bus ();

    dual_req_logic_arbiter dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    bit       grant_q[$];
    bit [8:0] result_q[$];   // {done_id, result}

    int cycle      = 0;
    int gnt_cycle  = -100;

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: samples just after each rising edge.
    always @(posedge clk) begin
        #1;
        cycle++;
        if (bus.gnt0 === 1'b1 && bus.gnt1 === 1'b1)
            check("gnt_exclusive", 16'd1, 16'd0);
        if (bus.gnt0 === 1'b1 || bus.gnt1 === 1'b1) begin
            if (grant_q.size() == 0) begin
                check("unexpected_grant", {bus.gnt1, bus.gnt0}, 16'd0);
            end else begin
                bit exp_id;
                exp_id = grant_q.pop_front();
                check("grant_id", bus.gnt1, exp_id);
                gnt_cycle = cycle;
            end
        end
        if (bus.done === 1'b1) begin
            if (result_q.size() == 0) begin
                check("unexpected_done", bus.done, 16'd0);
            end else begin
                bit [8:0] exp;
                exp = result_q.pop_front();
                check("done_latency", 16'(cycle - gnt_cycle), 16'd2);
                check("done_id", bus.done_id, exp[8]);
                check("result", bus.result, exp[7:0]);
            end
        end
    end

    task automatic clear_inputs();
        bus.req0 = 0; bus.req1 = 0;
        bus.op0 = 0; bus.op1 = 0;
        bus.a0 = 0; bus.b0 = 0; bus.a1 = 0; bus.b1 = 0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 0;
        repeat (2) @(negedge clk);
        check("rst_gnt0", bus.gnt0, 0);
        check("rst_gnt1", bus.gnt1, 0);
        check("rst_busy", bus.busy, 0);
        check("rst_done", bus.done, 0);
        check("rst_done_id", bus.done_id, 0);
        check("rst_result", bus.result, 8'h00);
        rst_n = 1;
    endtask

    task automatic wait_gnt(input bit id, output bit seen);
        seen = 0;
        for (int i = 0; i < 10 && !seen; i++) begin
            @(negedge clk);
            if ((id == 0 && bus.gnt0 === 1'b1) || (id == 1 && bus.gnt1 === 1'b1))
                seen = 1;
        end
        if (!seen) check("grant_timeout", 0, 1);
    endtask

    // Single operation: hold request until grant, then drop it and wait for IDLE.
    task automatic issue(input bit id, input logic [1:0] op, input logic [7:0] a,
                         input logic [7:0] b, input logic [7:0] exp);
        bit seen;
        @(negedge clk);
        if (id == 0) begin
            bus.op0 = op; bus.a0 = a; bus.b0 = b; bus.req0 = 1;
        end else begin
            bus.op1 = op; bus.a1 = a; bus.b1 = b; bus.req1 = 1;
        end
        grant_q.push_back(id);
        result_q.push_back({id, exp});
        wait_gnt(id, seen);
        check("busy_in_load", bus.busy, 1);
        bus.req0 = 0; bus.req1 = 0;
        repeat (3) @(negedge clk);
        check("busy_idle_after", bus.busy, 0);
    endtask

    initial begin
        bit seen;
        rst_n = 0;
        clear_inputs();
        do_reset();

        // Single request, AND.
        issue(0, 2'b00, 8'hF0, 8'h3C, 8'h30);

        // Opcode sweep on requester 1.
        issue(1, 2'b01, 8'hF0, 8'h3C, 8'hFC);
        issue(1, 2'b10, 8'hF0, 8'h3C, 8'hCC);
        issue(1, 2'b11, 8'hF0, 8'h3C, 8'h33);

        // Continuous tie after reset: grants 0,1,0 three cycles apart.
        do_reset();
        @(negedge clk);
        bus.op0 = 2'b00; bus.a0 = 8'hF0; bus.b0 = 8'h3C;
        bus.op1 = 2'b10; bus.a1 = 8'hF0; bus.b1 = 8'h3C;
        bus.req0 = 1; bus.req1 = 1;
        grant_q.push_back(0); result_q.push_back({1'b0, 8'h30});
        grant_q.push_back(1); result_q.push_back({1'b1, 8'hCC});
        grant_q.push_back(0); result_q.push_back({1'b0, 8'h30});
        repeat (7) @(posedge clk);
        @(negedge clk);
        bus.req0 = 0; bus.req1 = 0;
        repeat (4) @(negedge clk);
        check("busy_after_ties", bus.busy, 0);

        // Operand change during EXEC must not affect the result.
        @(negedge clk);
        bus.op0 = 2'b10; bus.a0 = 8'hF0; bus.b0 = 8'h0F; bus.req0 = 1;
        grant_q.push_back(0); result_q.push_back({1'b0, 8'hFF});
        wait_gnt(0, seen);
        bus.req0 = 0;
        @(negedge clk);
        bus.a0 = 8'h00;
        repeat (3) @(negedge clk);

        // Reset sampled in EXEC aborts with no done; ties then go to requester 0.
        @(negedge clk);
        bus.op0 = 2'b00; bus.a0 = 8'hAA; bus.b0 = 8'h0F; bus.req0 = 1;
        grant_q.push_back(1'b0);
        wait_gnt(0, seen);
        bus.req0 = 0;
        @(negedge clk);
        rst_n = 0;
        bus.req0 = 1; bus.req1 = 1;
        @(negedge clk);
        check("abort_busy", bus.busy, 0);
        check("abort_result", bus.result, 8'h00);
        check("abort_done", bus.done, 0);
        check("abort_no_gnt", {bus.gnt1, bus.gnt0}, 0);
        rst_n = 1;
        grant_q.push_back(0); result_q.push_back({1'b0, 8'h0A});
        wait_gnt(0, seen);
        bus.req0 = 0; bus.req1 = 0;
        repeat (3) @(negedge clk);

        // req1 pulsed during LOAD/EXEC only: ignored.
        @(negedge clk);
        bus.op0 = 2'b01; bus.a0 = 8'h0F; bus.b0 = 8'hF0; bus.req0 = 1;
        grant_q.push_back(0); result_q.push_back({1'b0, 8'hFF});
        wait_gnt(0, seen);
        bus.req0 = 0; bus.req1 = 1;
        @(negedge clk);
        bus.req1 = 0;
        repeat (4) @(negedge clk);
        check("busy_after_ignored", bus.busy, 0);

        repeat (3) @(negedge clk);
        check("grant_q_drained", 16'(grant_q.size()), 0);
        check("result_q_drained", 16'(result_q.size()), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/dual_req_logic_arbiter.md
DUAL_REQ_LOGIC_ARBITER -- requirements
Module: dual_req_logic_arbiter

Interface
REQ-001 The block SHALL have one clock and a synchronous active-low reset: all state SHALL update on the rising edge of clk, and rst_n=0 sampled at a rising edge SHALL reset the block.
REQ-002 Port clk, input, 1 bit: sole clock; no logic on negedge.
REQ-003 Port rst_n, input, 1 bit: synchronous active-low reset.
REQ-004 Ports req0, req1, inputs, 1 bit each: operation request from requester 0/1.
REQ-005 Ports op0, op1, inputs, 2 bits each: operation code, 00=AND, 01=OR, 10=XOR, 11=XNOR.
REQ-006 Ports a0, b0, a1, b1, inputs, 8 bits each: operands of requester 0/1.
REQ-007 Ports gnt0, gnt1, outputs, 1 bit each: registered one-cycle grant pulse.
REQ-008 Port busy, output, 1 bit: high whenever state is not IDLE.
REQ-009 Port result, output, 8 bits: registered result of the shared logic unit.
REQ-010 Port done, output, 1 bit: one-cycle pulse; result is valid while done=1.
REQ-011 Port done_id, output, 1 bit: requester that owns the current result; valid while done=1.

Function
REQ-012 The FSM SHALL have four states: IDLE, LOAD, EXEC and DONE.
REQ-013 In IDLE or DONE, at an edge sampling req0|req1=1, the FSM SHALL go to LOAD, capture the winner's op, a and b into internal registers, and set that winner's gnt high for the LOAD cycle only.
REQ-014 In IDLE or DONE with no request, the FSM SHALL go to IDLE.
REQ-015 LOAD SHALL always go to EXEC at the next edge.
REQ-016 EXEC SHALL go to DONE at the next edge, registering result = op(a,b) bitwise on the captured operands and setting done=1 and done_id=winner.
REQ-017 done SHALL be high for exactly one cycle, the DONE cycle.
REQ-018 result SHALL hold its value until the next EXEC->DONE transition.
REQ-019 Latency: if req is sampled at edge k, gnt SHALL be high in cycle k..k+1 and done SHALL be high in cycle k+2..k+3.
REQ-020 Throughput SHALL be at most one operation per 3 cycles, back-to-back via DONE->LOAD.
REQ-021 Arbitration SHALL be round-robin: a register last_id holds the most recent winner.
REQ-022 With a single request, that requester SHALL win regardless of last_id.
REQ-023 With both requests, the requester != last_id SHALL win.
REQ-024 last_id SHALL update on every grant.
REQ-025 Requests SHALL be ignored in LOAD and EXEC; no grant SHALL be issued and no operand SHALL be captured in those states.
REQ-026 Handshake: a requester SHALL hold req, op and operands stable until it sees its gnt, and SHALL treat req still high at a later sampling edge as a new request.
REQ-027 Operand changes after the capture edge SHALL NOT affect result.
REQ-028 gnt0 and gnt1 SHALL never be high in the same cycle.

Reset
REQ-029 Reset SHALL set state=IDLE, gnt0=gnt1=0, busy=0, done=0, done_id=0, result=8'h00 and last_id=1, so requester 0 wins the first tie.
REQ-030 Reset sampled in any state, including mid-operation, SHALL abort the operation at that edge with no done pulse and no grant issued.
REQ-031 Requests sampled at the reset edge SHALL be discarded.

Verification
REQ-032 Single request: after reset, req0=1, op0=00, a0=F0, b0=3C sampled at edge k -> gnt0=1 in cycle k..k+1, busy=1, done=1 with result=30 and done_id=0 in cycle k+2..k+3, then IDLE with busy=0.
REQ-033 Opcode sweep: requester 1 with a1=F0, b1=3C and op1=01/10/11 -> result=FC/CC/33, done_id=1.
REQ-034 Simultaneous requests: req0=req1=1 held continuously after reset -> grants alternate gnt0, gnt1, gnt0, ... each 3 cycles apart, and done_id alternates 0, 1, 0.
REQ-035 Operand change after capture: a0 changes from F0 to 00 in the EXEC cycle -> result still computed from F0.
REQ-036 Reset mid-operation: rst_n=0 sampled in EXEC -> next cycle state=IDLE, result=00, no done pulse, and a following tie is granted to requester 0.
REQ-037 Ignored request: req1 rises during LOAD and drops before DONE -> no gnt1 and no second operation.
